// File: rtl/timer_isa_pkg.sv
// Shared constants for the timer ISA: opcodes, instruction field positions
// and the sequencer state encoding.
package timer_isa_pkg;

  // Default datapath widths
  localparam int PC_W_DEF = 8;
  localparam int IW_DEF   = 16;

  // Instruction field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcodes; 8..E are undefined and execute as NOP with the illegal flag set
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDC  = 4'h1;
  localparam logic [3:0] OP_DECC = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_JNZ  = 4'h4;
  localparam logic [3:0] OP_WAIT = 4'h5;
  localparam logic [3:0] OP_OUTC = 4'h6;
  localparam logic [3:0] OP_OUTI = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // True for the opcode range that has no defined meaning
  function automatic logic opc_undefined(input logic [3:0] opc);
    return (opc >= 4'h8) && (opc <= 4'hE);
  endfunction

endpackage

// File: rtl/timer_isa_decode.sv
// Combinational decoder: splits the latched instruction word into one-hot
// opcode flags and the immediate. NOP has no flag; it is the fall-through.
module timer_isa_decode
  import timer_isa_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic [IW-1:0]   ir,
  output logic            is_ldc,
  output logic            is_decc,
  output logic            is_jmp,
  output logic            is_jnz,
  output logic            is_wait,
  output logic            is_outc,
  output logic            is_outi,
  output logic            is_halt,
  output logic            is_illegal,
  output logic [PC_W-1:0] imm
);

  logic [3:0] opc;
  // Reserved bits [11:8] carry no meaning
  logic       unused_rsvd;

  assign opc         = ir[OPC_HI:OPC_LO];
  assign imm         = ir[IMM_HI:IMM_LO];
  assign unused_rsvd = ^ir[11:8];

  // Opcode to one-hot flag
  always_comb begin
    is_ldc     = 1'b0;
    is_decc    = 1'b0;
    is_jmp     = 1'b0;
    is_jnz     = 1'b0;
    is_wait    = 1'b0;
    is_outc    = 1'b0;
    is_outi    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = opc_undefined(opc);
    case (opc)
      OP_LDC:  is_ldc  = 1'b1;
      OP_DECC: is_decc = 1'b1;
      OP_JMP:  is_jmp  = 1'b1;
      OP_JNZ:  is_jnz  = 1'b1;
      OP_WAIT: is_wait = 1'b1;
      OP_OUTC: is_outc = 1'b1;
      OP_OUTI: is_outi = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/timer_sequencer.sv
// Timer ISA sequencer: fetches the ROM word at pc, executes it, and drives
// the PC's inc/load inputs back to close the fetch loop. Owns the loop
// counter, the wait-tick counter and the display register.
module timer_sequencer
  import timer_isa_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc,
  input  logic [IW-1:0]   instr,
  input  logic            tick,
  input  logic            start,
  input  logic            pause,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_load_val,
  output logic [PC_W-1:0] disp,
  output logic [PC_W-1:0] cnt,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [PC_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0] disp_q, disp_d;
  logic [PC_W-1:0] wcnt_q, wcnt_d;
  logic [PC_W-1:0] load_val_q;
  logic            illegal_q, illegal_d;

  logic            is_ldc, is_decc, is_jmp, is_jnz, is_wait;
  logic            is_outc, is_outi, is_halt, is_illegal;
  logic [PC_W-1:0] imm;

  // The PC value itself is not needed: the ROM word arrives alongside it
  logic            unused_pc;
  assign unused_pc = ^pc;

  timer_isa_decode #(
    .PC_W(PC_W),
    .IW  (IW)
  ) u_decode (
    .ir        (ir_q),
    .is_ldc    (is_ldc),
    .is_decc   (is_decc),
    .is_jmp    (is_jmp),
    .is_jnz    (is_jnz),
    .is_wait   (is_wait),
    .is_outc   (is_outc),
    .is_outi   (is_outi),
    .is_halt   (is_halt),
    .is_illegal(is_illegal),
    .imm       (imm)
  );

  // Next-state and strobe logic; strobes are combinational so the PC
  // updates on the edge that ends the EXEC/WAIT/HALT cycle
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    wcnt_d    = wcnt_q;
    illegal_d = illegal_q;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!pause) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Pause is deliberately ignored here: EXEC is always one cycle
        state_d = ST_FETCH;
        if (is_ldc) begin
          cnt_d  = imm;
          pc_inc = 1'b1;
        end else if (is_decc) begin
          cnt_d  = cnt_q - ONE;
          pc_inc = 1'b1;
        end else if (is_jmp) begin
          pc_load = 1'b1;
        end else if (is_jnz) begin
          // Tests the counter value held before this cycle
          if (cnt_q != '0) pc_load = 1'b1;
          else             pc_inc  = 1'b1;
        end else if (is_wait) begin
          if (imm == '0) begin
            pc_inc = 1'b1;
          end else begin
            wcnt_d  = imm;
            state_d = ST_WAIT;
          end
        end else if (is_outc) begin
          disp_d = cnt_q;
          pc_inc = 1'b1;
        end else if (is_outi) begin
          disp_d = imm;
          pc_inc = 1'b1;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          // NOP, and undefined opcodes which behave as NOP
          pc_inc = 1'b1;
          if (is_illegal) illegal_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Ticks arriving under pause are dropped, not queued
        if (tick && !pause) begin
          wcnt_d = wcnt_q - ONE;
          if (wcnt_q == ONE) begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        if (start) begin
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load value follows imm while loading and otherwise holds
  always_comb begin
    pc_load_val = pc_load ? imm : load_val_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      wcnt_q     <= '0;
      load_val_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      wcnt_q     <= wcnt_d;
      load_val_q <= pc_load_val;
      illegal_q  <= illegal_d;
    end
  end

  // Status outputs
  always_comb begin
    busy    = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_WAIT);
    halted  = (state_q == ST_HALT);
    cnt     = cnt_q;
    disp    = disp_q;
    illegal = illegal_q;
  end

endmodule
